spi_tx_arbiter: RTL and testbench
=================================

Name: spi_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 12-bit SPI master transmitter (newd/din in, cs out) between NREQ requesters.
- Accepts per-requester requests, latches the winner's word, and drives newd until the transmitter asserts cs low.
- Waits for cs to return high, then returns a one-cycle done pulse to the winner.
- Sits between client logic and the SPI master, in the same clk domain; the SPI master's sclk is derived from clk.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 12, data word width; matches the SPI master din.
- TIMEOUT, 64, max clk cycles to wait for cs to fall after newd is raised.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until the matching done pulse.
- req_data  in  NREQ*DW  packed words; requester i owns bits [i*DW +: DW].
- grant  out  NREQ  one-hot; the requester currently owning the transmitter.
- done  out  NREQ  one-cycle pulse to the requester whose word has been fully shifted.
- err  out  1  one-cycle pulse on start timeout.
- busy  out  1  high whenever state != IDLE.
- spi_newd  out  1  to the SPI master newd.
- spi_din  out  DW  to the SPI master din; stable while spi_newd is high.
- spi_cs  in  1  from the SPI master cs; low while a frame is in progress.

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - grant=0, done=0, err=0, busy=0, spi_newd=0, spi_din=0.
  - Round-robin pointer ptr=0, timeout counter=0, state=IDLE.
  - Reset mid-transfer drops spi_newd immediately; the SPI master's own frame is not aborted by this block.
- cs sampling: spi_cs is registered once (cs_q).
  - Falling edge detected when cs_q=1 and spi_cs=0.
  - Rising edge detected when cs_q=0 and spi_cs=1.
- FSM: IDLE -> ISSUE -> WAIT_END -> DONE -> IDLE.
  - IDLE: if any req bit is high, pick the first set bit searching from index ptr upward, wrapping modulo NREQ.
    - Set grant to that one-hot, latch spi_din = its req_data slice, set spi_newd=1, clear the counter, go to ISSUE.
    - Arbitration takes 1 cycle: the req seen at edge k gives grant/spi_newd at edge k+1.
  - ISSUE: hold spi_newd=1 and spi_din constant; counter increments each cycle.
    - On cs falling edge: spi_newd=0, go to WAIT_END.
    - If the counter reaches TIMEOUT-1 with no cs fall: spi_newd=0, err pulses 1 cycle, grant=0, ptr=winner+1, no done pulse, go to IDLE.
  - WAIT_END: spi_newd=0. On cs rising edge go to DONE. No timeout in this state.
  - DONE: for exactly one cycle, done[winner]=1. Then grant=0, ptr=(winner+1) mod NREQ, go to IDLE.
    - A new arbitration may start at the next edge; there is no idle gap beyond the single IDLE cycle.
- req and data handling:
  - req_data is sampled only at grant. Later changes have no effect on the frame in flight.
  - Deasserting the granted req mid-transfer does not abort; done still pulses.
  - req bits of non-granted requesters are ignored until IDLE.
- Simultaneous requests: exactly one grant. The order is rotating; fairness means each of NREQ continuously requesting clients is served once per NREQ transfers.
- Ignored event: a cs falling edge while in IDLE, WAIT_END or DONE is ignored.
- busy = (state != IDLE). grant is either all zero or one-hot; never more than one bit set.

Test Plan:
- Reset check: rst=1 for 3 cycles with req=4'b1111 -> all outputs 0, and no grant until the first posedge with rst=0.
- Single requester: req=4'b0100, req_data[2] = 12'hA5C, SPI model lowers cs 30 clks after newd and raises it 290 clks later.
  - Required: grant=4'b0100 one cycle later, spi_din=12'hA5C, spi_newd high until cs falls.
  - Required: done=4'b0100 for one cycle after cs rises; total 12 LSB-first bits observed on mosi = 0,0,1,1,1,0,1,0,0,1,0,1.
- Round-robin: req=4'b1111 held with distinct data 12'h001..12'h004 -> grant order 0001, 0010, 0100, 1000, 0001; each done pulses once per frame.
- Pointer wrap: serve req[3] first, then assert req=4'b1001 -> next grant is 4'b0001.
- Timeout: SPI model holds cs=1, req=4'b0001 -> err pulses exactly TIMEOUT cycles after spi_newd rises; spi_newd=0, no done, busy=0 afterwards.
- Mid-operation events:
  - Change req_data[0] to 12'hFFF and drop req[0] during WAIT_END -> the original word is transmitted and done[0] still pulses.
  - Assert rst during WAIT_END -> outputs clear next edge.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that shares one SPI master transmitter between NREQ requesters.
// Sequences newd/din against the master's cs and returns a done pulse to the winner.
module spi_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 12,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic                 busy,
   output logic                 spi_newd,
   output logic [DW-1:0]        spi_din,
   input  logic                 spi_cs
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, DONE} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [PW-1:0]   ptr_next;
   logic [CW-1:0]   cnt;
   logic            cs_q;
   logic            cs_fall;
   logic            cs_rise;
   logic            pick_ok;
   logic [PW-1:0]   pick_idx;
   int              j;

   assign cs_fall  = cs_q & ~spi_cs;
   assign cs_rise  = ~cs_q & spi_cs;
   assign busy     = (state != IDLE);
   assign ptr_next = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);

   // Scan from the highest offset down so the lowest offset from ptr wins.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = '0;
      j        = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % NREQ;
         if (req[j]) begin
            pick_ok  = 1'b1;
            pick_idx = PW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         done     <= '0;
         err      <= 1'b0;
         spi_newd <= 1'b0;
         spi_din  <= '0;
         ptr      <= '0;
         win      <= '0;
         cnt      <= '0;
         cs_q     <= 1'b1;
      end else begin
         cs_q <= spi_cs;
         done <= '0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_ok) begin
                  win      <= pick_idx;
                  grant    <= NREQ'(1) << pick_idx;
                  spi_din  <= req_data[int'(pick_idx)*DW +: DW];
                  spi_newd <= 1'b1;
                  cnt      <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (cs_fall) begin
                  spi_newd <= 1'b0;
                  state    <= WAIT_END;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  // Master never started: release the transmitter without a done pulse.
                  spi_newd <= 1'b0;
                  err      <= 1'b1;
                  grant    <= '0;
                  ptr      <= ptr_next;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_END: begin
               if (cs_rise) begin
                  done  <= grant;
                  state <= DONE;
               end
            end
            DONE: begin
               grant <= '0;
               ptr   <= ptr_next;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter with a behavioural SPI master answering newd with a cs frame.
module tb_spi_tx_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [47:0]   req_data;
   logic [3:0]    grant;
   logic [3:0]    done;
   logic          err;
   logic          busy;
   logic          spi_newd;
   logic [11:0]   spi_din;
   logic          spi_cs;

   logic          cs_hold = 1'b0;
   logic          newd_at_fall;
   logic [11:0]   mosi_seq;

   int            total = 0;
   int            bad = 0;

   spi_tx_arbiter #(.NREQ(4), .DW(12), .TIMEOUT(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .done     (done),
      .err      (err),
      .busy     (busy),
      .spi_newd (spi_newd),
      .spi_din  (spi_din),
      .spi_cs   (spi_cs)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // SPI master model: cs falls 30 clocks after newd, one bit every 24 clocks, cs rises 290 clocks later.
   initial begin
      spi_cs       = 1'b1;
      newd_at_fall = 1'b0;
      mosi_seq     = '0;
      forever begin
         @(negedge clk);
         if (spi_newd && !cs_hold) begin
            repeat (29) @(negedge clk);
            newd_at_fall = spi_newd;
            mosi_seq     = '0;
            spi_cs       = 1'b0;
            for (int b = 0; b < 12; b++) begin
               repeat (24) @(negedge clk);
               mosi_seq[b] = spi_din[b];
            end
            repeat (2) @(negedge clk);
            spi_cs = 1'b1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic [3:0] g, input logic [11:0] w);
      int n;
      n = 0;
      while (grant == 4'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("grant", {28'b0, grant}, {28'b0, g});
      check_eq("spi_din", {20'b0, spi_din}, {20'b0, w});
      n = 0;
      while (done == 4'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("done", {28'b0, done}, {28'b0, g});
      check_eq("newd_at_fall", {31'b0, newd_at_fall}, 32'd1);
      check_eq("mosi", {20'b0, mosi_seq}, {20'b0, w});
      @(negedge clk);
      check_eq("done_pulse", {28'b0, done}, 32'd0);
      check_eq("grant_clear", {28'b0, grant}, 32'd0);
   endtask

   task automatic wait_wait_end();
      int n;
      n = 0;
      while (!(busy && !spi_cs && !spi_newd) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_wait_end", {31'b0, (busy && !spi_cs && !spi_newd)}, 32'd1);
   endtask

   initial begin
      int n;
      logic done_seen;

      // Reset with every requester asking.
      rst      = 1'b1;
      req      = 4'b1111;
      req_data = {12'h004, 12'h003, 12'h002, 12'h001};
      repeat (3) @(negedge clk);
      check_eq("rst_grant", {28'b0, grant}, 32'd0);
      check_eq("rst_done", {28'b0, done}, 32'd0);
      check_eq("rst_err", {31'b0, err}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_newd", {31'b0, spi_newd}, 32'd0);
      check_eq("rst_din", {20'b0, spi_din}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("first_grant", {28'b0, grant}, 32'h1);
      check_eq("first_newd", {31'b0, spi_newd}, 32'd1);
      check_eq("first_busy", {31'b0, busy}, 32'd1);

      // Round robin over four continuously requesting clients.
      run_frame(4'b0001, 12'h001);
      run_frame(4'b0010, 12'h002);
      run_frame(4'b0100, 12'h003);
      run_frame(4'b1000, 12'h004);
      run_frame(4'b0001, 12'h001);
      req = 4'b0000;
      @(negedge clk);
      check_eq("idle_busy", {31'b0, busy}, 32'd0);

      // Single requester, one-cycle arbitration latency.
      req_data[2*12 +: 12] = 12'hA5C;
      req = 4'b0100;
      @(negedge clk);
      check_eq("single_latency", {28'b0, grant}, 32'h4);
      run_frame(4'b0100, 12'hA5C);
      req = 4'b0000;

      // Pointer wrap: after serving 3, requester 0 wins over 3.
      @(negedge clk);
      req = 4'b1000;
      run_frame(4'b1000, 12'h004);
      req = 4'b1001;
      run_frame(4'b0001, 12'h001);
      req = 4'b0000;
      @(negedge clk);

      // Start timeout: master never lowers cs.
      cs_hold = 1'b1;
      req     = 4'b0001;
      n = 0;
      while (!spi_newd && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_eq("to_newd_rise", {31'b0, spi_newd}, 32'd1);
      n = 0;
      done_seen = 1'b0;
      while (!err && n < 200) begin
         @(negedge clk);
         n++;
         if (done != 4'b0) done_seen = 1'b1;
      end
      check_eq("to_latency", n, 32'd64);
      check_eq("to_newd_low", {31'b0, spi_newd}, 32'd0);
      check_eq("to_grant", {28'b0, grant}, 32'd0);
      check_eq("to_busy", {31'b0, busy}, 32'd0);
      check_eq("to_no_done", {31'b0, done_seen}, 32'd0);
      req = 4'b0000;
      @(negedge clk);
      check_eq("to_err_pulse", {31'b0, err}, 32'd0);
      check_eq("to_busy_after", {31'b0, busy}, 32'd0);
      cs_hold = 1'b0;
      @(negedge clk);

      // Data change and req drop while waiting for the frame end.
      req_data[0 +: 12] = 12'h3C5;
      req = 4'b0001;
      wait_wait_end();
      req_data[0 +: 12] = 12'hFFF;
      req = 4'b0000;
      @(negedge clk);
      check_eq("mid_din_hold", {20'b0, spi_din}, 32'h3C5);
      n = 0;
      while (done == 4'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("mid_done", {28'b0, done}, 32'h1);
      check_eq("mid_mosi", {20'b0, mosi_seq}, 32'h3C5);
      @(negedge clk);
      check_eq("mid_done_pulse", {28'b0, done}, 32'd0);

      // Reset while waiting for the frame end.
      req = 4'b0010;
      wait_wait_end();
      rst = 1'b1;
      @(negedge clk);
      check_eq("wrst_grant", {28'b0, grant}, 32'd0);
      check_eq("wrst_busy", {31'b0, busy}, 32'd0);
      check_eq("wrst_newd", {31'b0, spi_newd}, 32'd0);
      check_eq("wrst_din", {20'b0, spi_din}, 32'd0);
      check_eq("wrst_done", {28'b0, done}, 32'd0);
      rst = 1'b0;
      req = 4'b0000;
      n = 0;
      done_seen = 1'b0;
      while (!spi_cs && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (4) begin
         @(negedge clk);
         if (done != 4'b0) done_seen = 1'b1;
      end
      check_eq("wrst_no_done", {31'b0, done_seen}, 32'd0);
      check_eq("wrst_idle", {31'b0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
